srsystem_rx_sequencer: RTL and testbench
========================================

Name: srsystem_rx_sequencer

Overview:
Receive sequencer for the serial reception system. It times and controls the reception of one frame: start bit, 8 data bits (LSB first), one parity bit, one stop bit. It detects the start bit, places sampling strobes mid-bit at OVERSAMPLE clocks per bit, and drives the shift-register strobe, clear and data-latch pulses. It checks parity and stop bit and runs the DRY/ERR acknowledge handshake with the consumer. It replaces hand-generated rxclk with a timed strobe in the clk domain.

Parameters:
OVERSAMPLE, 16, clk cycles per serial bit (even, >=4)
DATA_W, 8, data bits per frame
PARITY_ODD, 1, 1 = odd parity expected, 0 = even

Ports:
clk  in  1  system clock, OVERSAMPLE x bit rate
rst  in  1  asynchronous active-low reset
en  in  1  receiver enable
rx  in  1  serial line, idle high, asynchronous to clk
ack  in  1  consumer acknowledge of DRY/ERR
shift  out  1  one-cycle strobe: shift register captures rx_s (sampled bit)
rx_s  out  1  synchronized rx fed to shift register
clr  out  1  one-cycle clear pulse to shift register/counter
pd  out  1  one-cycle latch pulse to data latch (good frame only)
DRY  out  1  frame ready, held until ack
ERR  out  1  parity or stop error, held until ack
busy  out  1  high from START through STOP
bit_idx  out  4  data bit index 0..DATA_W-1, 0 outside DATA

Behaviour:
- Reset (rst=0, async): state IDLE. shift=clr=pd=DRY=ERR=busy=0. bit_idx=0. Synchronizer flops=1. Oversample counter=0. Parity accumulator=0.
- rx passes through a 2-flop synchronizer (rx_s) and a third flop (rx_d) for edge detect. Fixed 2-cycle input latency.
- Oversample counter cnt, width clog2(OVERSAMPLE). It zeroes on every state entry.
- IDLE: when en=1 and rx_d=1, rx_s=0 (falling edge) -> START, busy=1. Low level without an edge does not start a frame.
- START: at cnt=OVERSAMPLE/2-1, sample rx_s. If 0 -> DATA with cnt=0. If 1 (glitch) -> IDLE, busy=0, no ERR, no clr.
- DATA: at cnt=OVERSAMPLE-1, assert shift for 1 cycle, parity ^= rx_s, bit_idx++. After bit DATA_W-1 -> PARITY, bit_idx=0.
- PARITY: at cnt=OVERSAMPLE-1, record perr = (parity ^ rx_s) != PARITY_ODD. No shift strobe. Go to STOP.
- STOP: at cnt=OVERSAMPLE-1, sample rx_s.
  - If rx_s=1 and perr=0: pd=1 for that cycle, DRY=1 next cycle, go to DONE.
  - Otherwise: ERR=1, no pd, go to FAIL.
  - busy drops on leaving STOP.
- DONE/FAIL: hold DRY/ERR. rx activity is ignored (overrun frames are dropped). When ack=1: clear DRY/ERR, pulse clr 1 cycle, parity=0, go to IDLE. ack is level-sensitive and is ignored in all other states.
- en=0 in START..STOP: abort next cycle to IDLE with a clr pulse, no DRY/ERR, no pd. en=0 in DONE/FAIL does not clear the flags; only ack clears them.
- Simultaneous events:
  - ack in the same cycle that DRY rises has no effect; it is only sampled in DONE/FAIL.
  - A falling edge in the same cycle as the IDLE entry from ack is not detected. The next edge is required.
- DRY and ERR are never both 1. pd pulses exactly once per good frame.
- rst asserted mid-frame: immediate return to reset values. No pulses are emitted.

Test Plan:
- Good frame, PARITY_ODD=1, byte 0xA5: rx = 0,1,0,1,0,0,1,0,1,1(parity),1(stop), 16 clk per bit, edge at cycle T.
  - Expected: shift pulses at T+2+8+16k for k=1..8; rx_s at those strobes = 1,0,1,0,0,1,0,1.
  - Expected: pd at T+2+8+16*10, then DRY=1, ERR=0. ack=1 -> clr pulse, DRY=0, IDLE.
- Parity error: same frame with parity bit 0 -> 8 shift pulses, no pd, ERR=1 after the stop sample, DRY=0. ack clears ERR with a clr pulse.
- Stop error: valid parity, stop bit 0 -> ERR=1, no pd.
- Glitch start: rx low for 4 clk, then high -> START entered, reject at mid-bit, back to IDLE. No shift, no clr, no ERR.
- Abort/overrun:
  - en dropped after 3 data bits -> 3 shift pulses, then clr, IDLE, no flags.
  - Second frame sent while DRY held -> ignored, DRY stays 1, pd count stays 1.
- Reset: rst=0 mid-DATA -> all outputs 0 asynchronously. After release, a new 0x3C frame receives correctly (pd once, DRY=1).

Source files
------------

// File: rtl/srsystem_rx_sequencer.sv
// Receive sequencer for one serial frame: start, DATA_W data bits LSB first, parity, stop.
// Places mid-bit sampling strobes in the clk domain and runs the DRY/ERR acknowledge handshake.
module srsystem_rx_sequencer #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rx,
    input  logic       ack,
    output logic       shift,
    output logic       rx_s,
    output logic       clr,
    output logic       pd,
    output logic       DRY,
    output logic       ERR,
    output logic       busy,
    output logic [3:0] bit_idx
);

    localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [3:0]    IDX_LAST = 4'(DATA_W - 1);
    localparam logic          ODD      = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE,
        S_FAIL
    } state_t;

    state_t        state, state_next;
    logic          rx_meta, rx_d;
    logic [CW-1:0] cnt;
    logic          parity, perr;
    logic          bit_end;

    // Two-flop synchronizer plus one delay stage for falling-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign bit_end = (cnt == CNT_LAST);
    assign busy    = (state == S_START) || (state == S_DATA) ||
                     (state == S_PARITY) || (state == S_STOP);
    assign DRY     = (state == S_DONE);
    assign ERR     = (state == S_FAIL);

    always_comb begin
        state_next = state;
        shift      = 1'b0;
        clr        = 1'b0;
        pd         = 1'b0;
        if (busy && !en) begin
            clr        = 1'b1;
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en && rx_d && !rx_s)
                        state_next = S_START;
                end
                S_START: begin
                    if (cnt == CNT_MID)
                        state_next = rx_s ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (bit_end) begin
                        shift = 1'b1;
                        if (bit_idx == IDX_LAST)
                            state_next = S_PARITY;
                    end
                end
                S_PARITY: begin
                    if (bit_end)
                        state_next = S_STOP;
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (rx_s && !perr) begin
                            pd         = 1'b1;
                            state_next = S_DONE;
                        end else begin
                            state_next = S_FAIL;
                        end
                    end
                end
                S_DONE, S_FAIL: begin
                    if (ack) begin
                        clr        = 1'b1;
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Parity and bit index restart on every new start bit so an aborted frame leaves no residue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            parity  <= 1'b0;
            perr    <= 1'b0;
        end else begin
            state <= state_next;
            if ((state_next != state) || bit_end)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);

            if (clr || (state == S_IDLE)) begin
                parity  <= 1'b0;
                bit_idx <= '0;
            end else if (shift) begin
                parity  <= parity ^ rx_s;
                bit_idx <= (bit_idx == IDX_LAST) ? 4'd0 : bit_idx + 4'd1;
            end

            if (state == S_IDLE)
                perr <= 1'b0;
            else if ((state == S_PARITY) && bit_end && en)
                perr <= ((parity ^ rx_s) != ODD);
        end
    end

endmodule

// File: tb/tb_srsystem_rx_sequencer.sv
// Self-checking bench for srsystem_rx_sequencer: table frames, random frames against a
// parity/stop model, and hand sequences for glitch, abort, overrun, ack timing and reset.
module tb_srsystem_rx_sequencer;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst, en, rx, ack;
    logic       shift, rx_s, clr, pd, DRY, ERR, busy;
    logic [3:0] bit_idx;

    int vec_count   = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic shift_bits[$];
    int   shift_cycs[$];
    int   pd_total   = 0;
    int   pd_last    = 0;
    int   clr_total  = 0;
    int   both_total = 0;
    int   busy_total = 0;

    typedef struct {
        logic [7:0] data;
        logic       pbit;
        logic       stop;
        logic       exp_dry;
        logic       exp_err;
    } vec_t;

    vec_t vecs[7];

    srsystem_rx_sequencer #(.OVERSAMPLE(OS), .DATA_W(8), .PARITY_ODD(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .rx      (rx),
        .ack     (ack),
        .shift   (shift),
        .rx_s    (rx_s),
        .clr     (clr),
        .pd      (pd),
        .DRY     (DRY),
        .ERR     (ERR),
        .busy    (busy),
        .bit_idx (bit_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor samples on the falling edge, well away from the active edge.
    always @(negedge clk) begin
        if (shift) begin
            shift_bits.push_back(rx_s);
            shift_cycs.push_back(cyc);
        end
        if (pd) begin
            pd_total <= pd_total + 1;
            pd_last  <= cyc;
        end
        if (clr) clr_total <= clr_total + 1;
        if (DRY && ERR) both_total <= both_total + 1;
        if (busy) busy_total <= busy_total + 1;
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives the first nbits bits of a frame, OS cycles each; t0 is the cycle the start bit begins.
    task automatic apply_stimulus(input logic [7:0] data, input logic pbit, input logic stop,
                                  input int nbits, output int t0);
        logic [10:0] frame;
        frame = {stop, pbit, data, 1'b0};
        @(posedge clk);
        #1;
        t0 = cyc;
        for (int i = 0; i < nbits; i++) begin
            rx = frame[i];
            repeat (OS) @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] data, input logic pbit,
                             input logic stop, input logic exp_good);
        int         t0, sb, pb, cb, bb;
        logic [7:0] cap;
        sb = shift_bits.size();
        pb = pd_total;
        bb = both_total;
        apply_stimulus(data, pbit, stop, 11, t0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cap = '0;
        for (int i = 0; i < 8; i++)
            if (sb + i < shift_bits.size()) cap[i] = shift_bits[sb + i];
        check_output({tag, " shift count"}, shift_bits.size() - sb, 8);
        check_output({tag, " data"}, cap, data);
        if (shift_bits.size() >= sb + 8) begin
            check_output({tag, " first shift cycle"}, shift_cycs[sb] - t0, 2 + 8 + OS);
            check_output({tag, " last shift cycle"}, shift_cycs[sb + 7] - t0, 2 + 8 + 8 * OS);
        end
        check_output({tag, " pd count"}, pd_total - pb, exp_good ? 1 : 0);
        if (exp_good && (pd_total > pb))
            check_output({tag, " pd cycle"}, pd_last - t0, 2 + 8 + 10 * OS);
        check_output({tag, " DRY"}, DRY, exp_good);
        check_output({tag, " ERR"}, ERR, !exp_good);
        check_output({tag, " busy after"}, busy, 0);
        check_output({tag, " DRY&ERR"}, both_total - bb, 0);
        cb = clr_total;
        ack_pulse();
        repeat (2) @(posedge clk);
        #1;
        check_output({tag, " ack clr"}, clr_total - cb, 1);
        check_output({tag, " DRY cleared"}, DRY, 0);
        check_output({tag, " ERR cleared"}, ERR, 0);
    endtask

    initial begin
        int         t0, sb, pb, cb, bt;
        logic [7:0] d;
        logic       pbit, stop, good;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0};

        rst = 1'b0;
        en  = 1'b0;
        rx  = 1'b1;
        ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset shift", shift, 0);
        check_output("reset clr", clr, 0);
        check_output("reset pd", pd, 0);
        check_output("reset DRY", DRY, 0);
        check_output("reset ERR", ERR, 0);
        check_output("reset busy", busy, 0);
        check_output("reset bit_idx", bit_idx, 0);
        check_output("reset rx_s", rx_s, 1);
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        for (int v = 0; v < 7; v++) begin
            check_output($sformatf("vec%0d table", v), vecs[v].exp_dry, !vecs[v].exp_err);
            run_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].pbit, vecs[v].stop,
                      vecs[v].exp_dry);
        end

        // Glitch: short low pulse enters START but is rejected at mid-bit.
        sb = shift_bits.size();
        cb = clr_total;
        bt = busy_total;
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_output("glitch busy seen", busy_total > bt, 1);
        check_output("glitch shifts", shift_bits.size() - sb, 0);
        check_output("glitch clr", clr_total - cb, 0);
        check_output("glitch ERR", ERR, 0);
        check_output("glitch busy", busy, 0);

        // Abort: en dropped during the fourth data bit.
        sb = shift_bits.size();
        cb = clr_total;
        pb = pd_total;
        apply_stimulus(8'h0B, 1'b0, 1'b1, 4, t0);
        repeat (4) @(posedge clk);
        #1;
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx = 1'b1;
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("abort shifts", shift_bits.size() - sb, 3);
        check_output("abort clr", clr_total - cb, 1);
        check_output("abort pd", pd_total - pb, 0);
        check_output("abort DRY", DRY, 0);
        check_output("abort ERR", ERR, 0);
        check_output("abort busy", busy, 0);
        check_output("abort bit_idx", bit_idx, 0);

        // Overrun: a second frame while DRY is held is dropped.
        sb = shift_bits.size();
        pb = pd_total;
        apply_stimulus(8'h5A, 1'b1, 1'b1, 11, t0);
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        apply_stimulus(8'h12, 1'b1, 1'b1, 11, t0);
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_output("overrun DRY", DRY, 1);
        check_output("overrun pd", pd_total - pb, 1);
        check_output("overrun shifts", shift_bits.size() - sb, 8);
        cb = clr_total;
        ack_pulse();
        #1;
        check_output("overrun ack clr", clr_total - cb, 1);
        check_output("overrun DRY cleared", DRY, 0);

        // ack in the pd cycle is ignored; DRY must still rise and stay.
        pb = pd_total;
        cb = clr_total;
        fork
            apply_stimulus(8'h96, 1'b1, 1'b1, 11, t0);
            begin
                @(posedge clk);
                repeat (2 + 8 + 10 * OS) @(posedge clk);
                #1;
                ack = 1'b1;
                @(posedge clk);
                #1;
                ack = 1'b0;
            end
        join
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("early ack DRY", DRY, 1);
        check_output("early ack clr", clr_total - cb, 0);
        check_output("early ack pd", pd_total - pb, 1);
        ack_pulse();
        #1;
        check_output("early ack cleared", DRY, 0);

        // Asynchronous reset in the middle of DATA.
        apply_stimulus(8'h77, 1'b0, 1'b1, 4, t0);
        pb = pd_total;
        cb = clr_total;
        sb = shift_bits.size();
        #2;
        rst = 1'b0;
        #1;
        check_output("midreset busy", busy, 0);
        check_output("midreset bit_idx", bit_idx, 0);
        check_output("midreset rx_s", rx_s, 1);
        check_output("midreset shift", shift, 0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("midreset no pulses", (pd_total - pb) + (clr_total - cb) +
                     (shift_bits.size() - sb), 0);
        check_output("midreset DRY", DRY, 0);
        run_frame("post-reset 3C", 8'h3C, 1'b1, 1'b1, 1'b1);

        // Random frames against the odd-parity / stop-bit model.
        for (int r = 0; r < 16; r++) begin
            d    = 8'($urandom_range(0, 255));
            pbit = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 3) != 0);
            good = stop && ((($countones(d) + pbit) % 2) == 1);
            run_frame($sformatf("rand%0d d=%02h p=%0b s=%0b", r, d, pbit, stop),
                      d, pbit, stop, good);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
